// File: rtl/cache_pkg.sv
// Shared types for the 2-way cache: controller state and the per-way line view.
// Lines are carried at LINE_W bits so any DATA_WIDTH up to 64 fits without retyping.
package cache_pkg;

    localparam int LINE_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [LINE_W-1:0] tag;
        logic [LINE_W-1:0] data;
    } line_t;

endpackage

// File: rtl/cache_way.sv
// One way of the cache: per-set valid bit, tag and data word.
// Valid bits clear on reset; tag/data storage is left untouched.
module cache_way
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SET_BITS   = 3,
    parameter int TAG_BITS   = DATA_WIDTH - SET_BITS - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SET_BITS-1:0]   rd_set,
    output line_t                 rd_line,
    input  logic                  wr_en,
    input  logic [SET_BITS-1:0]   wr_set,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam int SETS = 1 << SET_BITS;

    logic [SETS-1:0]       valid_arr;
    logic [TAG_BITS-1:0]   tag_arr  [SETS];
    logic [DATA_WIDTH-1:0] data_arr [SETS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_arr <= '0;
        end else if (wr_en) begin
            valid_arr[wr_set] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_arr[wr_set]  <= wr_tag;
            data_arr[wr_set] <= wr_data;
        end
    end

    always_comb begin
        rd_line       = '0;
        rd_line.valid = valid_arr[rd_set];
        rd_line.tag   = LINE_W'(tag_arr[rd_set]);
        rd_line.data  = LINE_W'(data_arr[rd_set]);
    end

endmodule

// File: rtl/cache_2w.sv
// 2-way set-associative, write-through / no-write-allocate data cache with one LRU bit per set.
// CPU inputs are held by the pipeline while stalled, so the access is decoded straight from addr.
module cache_2w
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SET_BITS   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  hit,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output state_t                dbg_state
);

    localparam int TAG_BITS = DATA_WIDTH - SET_BITS - 2;
    localparam int SETS     = 1 << SET_BITS;

    state_t state, state_nxt;

    logic [SET_BITS-1:0]   req_set;
    logic [TAG_BITS-1:0]   req_tag;
    logic [DATA_WIDTH-1:0] word_addr;
    line_t                 line0, line1;
    logic                  hit0, hit1;
    logic                  victim;
    logic [1:0]            wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [SETS-1:0]       lru;  // 1 = way 1 is next to be evicted
    logic                  lru_upd, lru_val;

    assign req_set   = addr[SET_BITS+1:2];
    assign req_tag   = addr[DATA_WIDTH-1:SET_BITS+2];
    assign word_addr = {addr[DATA_WIDTH-1:2], 2'b00};
    assign hit0      = line0.valid && (line0.tag == LINE_W'(req_tag));
    assign hit1      = line1.valid && (line1.tag == LINE_W'(req_tag));
    assign victim    = !line0.valid ? 1'b0 : (!line1.valid ? 1'b1 : lru[req_set]);
    assign dbg_state = state;

    cache_way #(.DATA_WIDTH(DATA_WIDTH), .SET_BITS(SET_BITS)) u_way0 (
        .clk(clk), .rst(rst), .rd_set(req_set), .rd_line(line0),
        .wr_en(wr_en[0]), .wr_set(req_set), .wr_tag(req_tag), .wr_data(wr_data)
    );

    cache_way #(.DATA_WIDTH(DATA_WIDTH), .SET_BITS(SET_BITS)) u_way1 (
        .clk(clk), .rst(rst), .rd_set(req_set), .rd_line(line1),
        .wr_en(wr_en[1]), .wr_set(req_set), .wr_tag(req_tag), .wr_data(wr_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            lru   <= '0;
        end else begin
            state <= state_nxt;
            if (lru_upd) lru[req_set] <= lru_val;
        end
    end

    always_comb begin
        state_nxt = state;
        rdata     = '0;
        hit       = 1'b0;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wr_en     = 2'b00;
        wr_data   = '0;
        lru_upd   = 1'b0;
        lru_val   = 1'b0;
        // Reset dominates: all outputs quiet and any in-flight access is dropped.
        if (!rst) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req && we) begin
                        stall     = 1'b1;
                        state_nxt = WRITE;
                    end else if (req && (hit0 || hit1)) begin
                        hit     = 1'b1;
                        rdata   = hit0 ? DATA_WIDTH'(line0.data) : DATA_WIDTH'(line1.data);
                        lru_upd = 1'b1;
                        lru_val = hit0;
                    end else if (req) begin
                        stall     = 1'b1;
                        state_nxt = FILL;
                    end
                end
                FILL: begin
                    mem_req  = 1'b1;
                    mem_addr = word_addr;
                    stall    = 1'b1;
                    if (mem_ready) begin
                        wr_en[victim] = 1'b1;
                        wr_data       = mem_rdata;
                        rdata         = mem_rdata;
                        stall         = 1'b0;
                        lru_upd       = 1'b1;
                        lru_val       = ~victim;
                        state_nxt     = IDLE;
                    end
                end
                WRITE: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = word_addr;
                    mem_wdata = wdata;
                    stall     = 1'b1;
                    if (mem_ready) begin
                        // Write-through: only a resident word is refreshed, misses leave the array alone.
                        wr_en     = {hit1, hit0};
                        wr_data   = wdata;
                        lru_upd   = hit0 || hit1;
                        lru_val   = hit0;
                        stall     = 1'b0;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: doc/cache_2w.md
CACHE_2W -- requirements
Module: cache_2w

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, address and data word width.
REQ-002 SHALL have parameter SET_BITS, default 3, log2 of set count (8 sets).
REQ-003 SHALL derive TAG_BITS = DATA_WIDTH - SET_BITS - 2; address layout is tag | set | 2-bit byte offset (offset ignored).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, reset (synchronous, active-low).
REQ-006 SHALL have port req, input, 1, CPU access request (load or store).
REQ-007 SHALL have port we, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port addr, input, DATA_WIDTH, byte address from ALU.
REQ-009 SHALL have port wdata, input, DATA_WIDTH, store data.
REQ-010 SHALL have port rdata, output, DATA_WIDTH, load data.
REQ-011 SHALL have port hit, output, 1, load hit this cycle.
REQ-012 SHALL have port stall, output, 1, pipeline hold request.
REQ-013 SHALL have port mem_req, output, 1, memory request.
REQ-014 SHALL have port mem_we, output, 1, memory write.
REQ-015 SHALL have port mem_addr, output, DATA_WIDTH, word-aligned memory address.
REQ-016 SHALL have port mem_wdata, output, DATA_WIDTH, memory write data.
REQ-017 SHALL have port mem_ready, input, 1, memory completes the request this cycle.
REQ-018 SHALL have port mem_rdata, input, DATA_WIDTH, memory read data, valid with mem_ready.

Function
REQ-019 SHALL be 2-way set-associative; each way/set holds valid bit, tag, one data word; one LRU bit per set.
REQ-020 SHALL use FSM states IDLE, FILL, WRITE.
REQ-021 In IDLE with req=1, we=0 and tag match on a valid way: hit=1, rdata=matching word combinationally, stall=0, LRU points to the other way next edge.
REQ-022 Load miss in IDLE: stall=1 same cycle, go to FILL.
REQ-023 In FILL: mem_req=1, mem_we=0, mem_addr={addr[DATA_WIDTH-1:2],2'b00}, stall=1.
REQ-024 On mem_ready in FILL: write victim way (invalid way first, way 0 if both invalid, else LRU way) with valid=1, tag, mem_rdata; rdata=mem_rdata and hit=0 that cycle; stall=0; LRU points away from the filled way; return to IDLE.
REQ-025 Store in IDLE: write-through, no write-allocate; go to WRITE, stall=1 same cycle.
REQ-026 In WRITE: mem_req=1, mem_we=1, mem_addr as REQ-023, mem_wdata=wdata, stall=1.
REQ-027 On mem_ready in WRITE: if the tag hits a valid way, update that word and the LRU; else leave the array unchanged; stall=0; return to IDLE.
REQ-028 CPU inputs SHALL be held stable by the pipeline while stall=1; the cache SHALL NOT latch them.
REQ-029 req=0 in IDLE: no state change, hit=0, stall=0, mem_req=0.
REQ-030 mem_ready outside FILL/WRITE SHALL be ignored.
REQ-031 Outside the active cases, rdata=0, mem_addr=0, mem_wdata=0.

Reset
REQ-032 rst=0 at a rising edge SHALL clear all valid and LRU bits and force IDLE, including mid-FILL/WRITE (the in-flight access is abandoned).
REQ-033 During and after reset: hit=0, stall=0, mem_req=0, mem_we=0, rdata=0; tag and data storage are not reset.

Structure
REQ-034 Package cache_pkg SHALL hold the FSM state enum and a line struct {valid, tag, data}.
REQ-035 Sub-module cache_way (one way's valid/tag/data arrays, read port and write port) SHALL be instantiated twice.

Verification
REQ-036 After reset, load 0x100 -> stall=1, mem_req, mem_addr=0x100; mem_ready with mem_rdata=0xDEADBEEF -> rdata=0xDEADBEEF, stall=0; repeat load -> hit=1 in 1 cycle.
REQ-037 Loads 0x100, 0x120, 0x140 (same set 0, SET_BITS=3) -> third fill evicts 0x100 (LRU); load 0x120 hits; load 0x100 misses.
REQ-038 Store 0x100 with 0x12345678 after fill -> mem_we=1, mem_wdata=0x12345678; next load 0x100 hits with 0x12345678.
REQ-039 Store to uncached 0x200 -> memory write only; next load 0x200 misses.
REQ-040 Assert rst=0 in FILL before mem_ready -> IDLE, stall=0, mem_req=0; load 0x100 misses.
REQ-041 Hold mem_ready=0 for 5 cycles in FILL -> stall stays 1 and mem_addr stable throughout.
